fetch_redirect_ctrl: RTL and testbench

Sequencing controller for the pre-IF fetch stage and its icache request port.
- Merges all PC redirect sources (boot, exception, ERET, TLB-op refetch, branch correction) into one registered redirect per cycle, by fixed priority.
- Gates new icache requests on an in-flight limit.
- Tracks accepted-but-unreturned icache transactions; silently discards returns belonging to a redirected (wrong) path.
- Sits between the CP0/branch-resolution flush logic and pre-IF/IF; pre-IF loads its PC from redirect_pc when redirect_valid is high.

---
 rtl/fetch_redirect_ctrl_pkg.sv | 38 +++
 rtl/fetch_redirect_ctrl_txn_counter.sv | 30 +++
 rtl/fetch_redirect_ctrl.sv | 148 ++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
package fetch_redirect_ctrl_pkg;

  localparam logic [31:0] BOOT_VEC   = 32'hbfc00000;
  localparam logic [31:0] EXC_VEC    = 32'hbfc00380;
  localparam logic [31:0] REFILL_VEC = 32'hbfc00200;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } redirect_bus_t;

  typedef enum logic [2:0] {
    EX    = 3'd0,
    ERET  = 3'd1,
    TLBOP = 3'd2,
    CORR  = 3'd3,
    NONE  = 3'd4
  } redirect_src_e;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // Fixed-priority pick of the redirect source.
  function automatic redirect_src_e select_src(input logic ex, input logic eret,
                                               input logic tlbop, input logic corr);
    redirect_src_e s;
    if (ex)         s = EX;
    else if (eret)  s = ERET;
    else if (tlbop) s = TLBOP;
    else if (corr)  s = CORR;
    else            s = NONE;
    return s;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_txn_counter.sv
// Up/down saturating transaction counter with parallel load.
module fetch_txn_counter #(
  parameter int MAX = 2,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  // Load has priority; simultaneous inc and dec cancel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && !dec && count != W'(MAX)) begin
      count <= count + W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect merge, icache in-flight gating and stale-return discard.
// Optional build macro FETCH_DRAIN_HOLD_EN blocks new requests while draining.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int          MAX_INFLIGHT = 2,
  parameter logic [31:0] RESET_PC     = 32'hbfc00000
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              ex_flush,
  input  logic                              ex_tlb_refill,
  input  logic                              eret_flush,
  input  logic [31:0]                       c0_epc,
  input  logic                              tlbop_flush,
  input  logic [31:0]                       tlb_pc,
  input  logic                              is_correction,
  input  logic [31:0]                       correct_target,
  input  logic                              icache_req,
  input  logic                              icache_addr_ok,
  input  logic                              icache_data_ok,
  output logic                              redirect_valid,
  output logic [31:0]                       redirect_pc,
  output logic                              req_allow,
  output logic                              fs_data_ok,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              proto_err
);

  localparam int W = $clog2(MAX_INFLIGHT + 1);

  redirect_bus_t redirect_q;
  redirect_src_e src;
  fetch_state_e  state;
  logic          boot_pending;
  logic          flush_any;
  logic          accept;
  logic          ret_eff;
  logic [31:0]   target_pc;
  logic [W-1:0]  inflight_nxt;
  logic [W-1:0]  disc;

  assign flush_any = ex_flush | eret_flush | tlbop_flush | is_correction;
  assign accept    = icache_req & icache_addr_ok;
  // A return with nothing outstanding is a protocol error and is not counted.
  assign ret_eff   = icache_data_ok & (inflight != '0);
  assign src       = select_src(ex_flush, eret_flush, tlbop_flush, is_correction);

  always_comb begin
    target_pc = RESET_PC;
    case (src)
      EX:      target_pc = ex_tlb_refill ? REFILL_VEC : EXC_VEC;
      ERET:    target_pc = c0_epc;
      TLBOP:   target_pc = tlb_pc + 32'd4;
      CORR:    target_pc = correct_target;
      default: target_pc = RESET_PC;
    endcase
  end

  always_comb begin
    inflight_nxt = inflight;
    if (accept && !ret_eff && inflight != W'(MAX_INFLIGHT)) begin
      inflight_nxt = inflight + W'(1);
    end else if (!accept && ret_eff) begin
      inflight_nxt = inflight - W'(1);
    end else begin
      inflight_nxt = inflight;
    end
  end

  fetch_txn_counter #(.MAX(MAX_INFLIGHT), .W(W)) u_inflight (
    .clk      (clk),
    .resetn   (resetn),
    .inc      (accept),
    .dec      (ret_eff),
    .load     (1'b0),
    .load_val ({W{1'b0}}),
    .count    (inflight)
  );

  // On redirect, everything still outstanding after this cycle is stale.
  fetch_txn_counter #(.MAX(MAX_INFLIGHT), .W(W)) u_disc (
    .clk      (clk),
    .resetn   (resetn),
    .inc      (1'b0),
    .dec      (ret_eff),
    .load     (flush_any),
    .load_val (inflight_nxt),
    .count    (disc)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      redirect_q   <= '{valid: 1'b0, pc: RESET_PC};
      boot_pending <= 1'b1;
    end else begin
      boot_pending <= 1'b0;
      if (flush_any) begin
        redirect_q <= '{valid: 1'b1, pc: target_pc};
      end else if (boot_pending) begin
        redirect_q <= '{valid: 1'b1, pc: RESET_PC};
      end else begin
        redirect_q <= '{valid: 1'b0, pc: redirect_q.pc};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (flush_any && inflight_nxt != '0) state <= DRAIN;
          else                                 state <= RUN;
        end
        DRAIN: begin
          if (flush_any)                        state <= (inflight_nxt != '0) ? DRAIN : RUN;
          else if (ret_eff && disc == W'(1))    state <= RUN;
          else                                  state <= DRAIN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      proto_err <= 1'b0;
    end else if ((icache_data_ok && inflight == '0) ||
                 (accept && !icache_data_ok && inflight == W'(MAX_INFLIGHT))) begin
      proto_err <= 1'b1;
    end else begin
      proto_err <= proto_err;
    end
  end

  assign redirect_valid = redirect_q.valid;
  assign redirect_pc    = redirect_q.pc;
  assign fs_data_ok     = resetn & icache_data_ok & (state == RUN) & ~flush_any;

`ifdef FETCH_DRAIN_HOLD_EN
  assign req_allow = resetn & (inflight < W'(MAX_INFLIGHT)) & ~redirect_q.valid & (state == RUN);
`else
  assign req_allow = resetn & (inflight < W'(MAX_INFLIGHT)) & ~redirect_q.valid;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl (MAX_INFLIGHT = 2).
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_flush, ex_tlb_refill, eret_flush, tlbop_flush, is_correction;
  logic [31:0] c0_epc, tlb_pc, correct_target;
  logic        icache_req, icache_addr_ok, icache_data_ok;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_allow, fs_data_ok, proto_err;
  logic [1:0]  inflight;

  int errors = 0;
  int checks = 0;

`ifdef FETCH_DRAIN_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.MAX_INFLIGHT(2), .RESET_PC(32'hbfc00000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ex_flush       (ex_flush),
    .ex_tlb_refill  (ex_tlb_refill),
    .eret_flush     (eret_flush),
    .c0_epc         (c0_epc),
    .tlbop_flush    (tlbop_flush),
    .tlb_pc         (tlb_pc),
    .is_correction  (is_correction),
    .correct_target (correct_target),
    .icache_req     (icache_req),
    .icache_addr_ok (icache_addr_ok),
    .icache_data_ok (icache_data_ok),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_allow      (req_allow),
    .fs_data_ok     (fs_data_ok),
    .inflight       (inflight),
    .proto_err      (proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ex_flush = 1'b0; ex_tlb_refill = 1'b0; eret_flush = 1'b0; tlbop_flush = 1'b0;
    is_correction = 1'b0; icache_req = 1'b0; icache_addr_ok = 1'b0; icache_data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    c0_epc = 32'h0; tlb_pc = 32'h0; correct_target = 32'h0;
    clear_in();
    repeat (3) tick();
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_pc", redirect_pc, 32'hbfc00000);
    chk("rst_inflight", {30'd0, inflight}, 32'd0);
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    chk("rst_allow", {31'd0, req_allow}, 32'd0);

    // Boot redirect
    resetn = 1'b1;
    tick();
    chk("boot_rv", {31'd0, redirect_valid}, 32'd1);
    chk("boot_pc", redirect_pc, 32'hbfc00000);
    chk("boot_allow0", {31'd0, req_allow}, 32'd0);
    tick();
    chk("boot_rv_drop", {31'd0, redirect_valid}, 32'd0);
    chk("boot_allow1", {31'd0, req_allow}, 32'd1);

    // Fill to MAX_INFLIGHT
    icache_req = 1'b1; icache_addr_ok = 1'b1;
    tick();
    chk("fill1", {30'd0, inflight}, 32'd1);
    tick();
    chk("fill2", {30'd0, inflight}, 32'd2);
    chk("full_allow", {31'd0, req_allow}, 32'd0);
    icache_data_ok = 1'b1;
    #1;
    chk("full_acc_ret_fs", {31'd0, fs_data_ok}, 32'd1);
    tick();
    chk("full_acc_ret_cnt", {30'd0, inflight}, 32'd2);
    chk("full_acc_ret_perr", {31'd0, proto_err}, 32'd0);
    clear_in();

    // Correction with two outstanding -> both returns discarded
    is_correction = 1'b1; correct_target = 32'h80001000;
    tick();
    clear_in();
    chk("corr_rv", {31'd0, redirect_valid}, 32'd1);
    chk("corr_pc", redirect_pc, 32'h80001000);
    chk("corr_allow", {31'd0, req_allow}, 32'd0);
    tick();
    chk("corr_rv_drop", {31'd0, redirect_valid}, 32'd0);
    icache_data_ok = 1'b1;
    #1;
    chk("stale1_fs", {31'd0, fs_data_ok}, 32'd0);
    tick();
    chk("stale1_cnt", {30'd0, inflight}, 32'd1);
    chk("drain_allow", {31'd0, req_allow}, {31'd0, ~HOLD});
    #1;
    chk("stale2_fs", {31'd0, fs_data_ok}, 32'd0);
    tick();
    chk("stale2_cnt", {30'd0, inflight}, 32'd0);
    icache_data_ok = 1'b0;
    chk("drained_allow", {31'd0, req_allow}, 32'd1);
    icache_req = 1'b1; icache_addr_ok = 1'b1;
    tick();
    clear_in();
    icache_data_ok = 1'b1;
    #1;
    chk("newpath_fs", {31'd0, fs_data_ok}, 32'd1);
    tick();
    clear_in();
    chk("newpath_cnt", {30'd0, inflight}, 32'd0);

    // Simultaneous sources, TLB refill vector wins
    ex_flush = 1'b1; ex_tlb_refill = 1'b1; eret_flush = 1'b1; is_correction = 1'b1;
    c0_epc = 32'h12345678; correct_target = 32'h80002000;
    tick();
    clear_in();
    chk("prio_rv", {31'd0, redirect_valid}, 32'd1);
    chk("prio_pc", redirect_pc, 32'hbfc00200);
    tick();
    chk("prio_one_cycle", {31'd0, redirect_valid}, 32'd0);

    ex_flush = 1'b1; eret_flush = 1'b1;
    tick();
    clear_in();
    chk("exc_pc", redirect_pc, 32'hbfc00380);
    eret_flush = 1'b1; tlbop_flush = 1'b1; tlb_pc = 32'h00400000;
    tick();
    clear_in();
    chk("eret_pc", redirect_pc, 32'h12345678);
    tlbop_flush = 1'b1; is_correction = 1'b1;
    tick();
    clear_in();
    chk("tlbop_pc", redirect_pc, 32'h00400004);
    tlbop_flush = 1'b1; tlb_pc = 32'hfffffffc;
    tick();
    clear_in();
    chk("tlbop_wrap_pc", redirect_pc, 32'h00000000);
    tick();

    // Return in the flush cycle is suppressed and not counted as stale
    icache_req = 1'b1; icache_addr_ok = 1'b1;
    tick();
    clear_in();
    icache_data_ok = 1'b1; is_correction = 1'b1; correct_target = 32'h80003000;
    #1;
    chk("flush_ret_fs", {31'd0, fs_data_ok}, 32'd0);
    tick();
    clear_in();
    chk("flush_ret_cnt", {30'd0, inflight}, 32'd0);
    tick();
    icache_req = 1'b1; icache_addr_ok = 1'b1;
    tick();
    clear_in();
    icache_data_ok = 1'b1;
    #1;
    chk("flush_ret_no_disc", {31'd0, fs_data_ok}, 32'd1);
    tick();
    clear_in();

    // Spurious return with nothing outstanding
    chk("perr_before", {31'd0, proto_err}, 32'd0);
    icache_data_ok = 1'b1;
    tick();
    clear_in();
    chk("perr_set", {31'd0, proto_err}, 32'd1);
    chk("perr_cnt", {30'd0, inflight}, 32'd0);
    tick();
    chk("perr_sticky", {31'd0, proto_err}, 32'd1);

    // Reset in the middle of a drain
    icache_req = 1'b1; icache_addr_ok = 1'b1;
    tick();
    clear_in();
    is_correction = 1'b1; correct_target = 32'h80004000;
    tick();
    clear_in();
    tick();
    chk("mid_drain_allow", {31'd0, req_allow}, {31'd0, ~HOLD});
    resetn = 1'b0;
    tick();
    chk("mrst_cnt", {30'd0, inflight}, 32'd0);
    chk("mrst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("mrst_pc", redirect_pc, 32'hbfc00000);
    chk("mrst_perr", {31'd0, proto_err}, 32'd0);
    chk("mrst_allow", {31'd0, req_allow}, 32'd0);
    resetn = 1'b1;
    tick();
    chk("reboot_rv", {31'd0, redirect_valid}, 32'd1);
    chk("reboot_pc", redirect_pc, 32'hbfc00000);
    tick();
    chk("reboot_allow", {31'd0, req_allow}, 32'd1);
    icache_req = 1'b1; icache_addr_ok = 1'b1;
    tick();
    clear_in();
    icache_data_ok = 1'b1;
    #1;
    chk("reboot_fs", {31'd0, fs_data_ok}, 32'd1);
    tick();
    clear_in();
    chk("reboot_cnt", {30'd0, inflight}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
